bcd_scan_display: RTL

- Consumer end of the BCD counter chain: takes NUM_DIGITS packed BCD digits from counters and drives a time-multiplexed, common-anode 7-segment display.
- Owns the refresh prescaler, digit scan index, frame-synchronous snapshot of inputs, BCD-to-segment decode, leading-zero blanking and anode ghosting guard.
- Sits between the counter bank and the board display pins.

---
 rtl/bcd_scan_display_if.sv | 23 ++
 rtl/bcd_scan_display.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bcd_scan_display_if.sv
// Display-side bundle for bcd_scan_display: BCD digit inputs from the counter
// bank and the multiplexed 7-segment pin outputs.
interface bcd_scan_display_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output digits_in, dp_in, digit_en,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  digits_in, dp_in, digit_en,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous input
// snapshot, leading-zero blanking and an anode-off guard at each slot start.
module bcd_scan_display #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned GUARD         = 2,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input logic               clk,
    input logic               rst,
    bcd_scan_display_if.slave bus
);
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    primed;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blank_nx;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [6:0]              seg_q;
    logic [6:0]              seg_nx;
    logic [6:0]              glyph;
    logic [3:0]              cur_dig;
    logic                    dp_q;
    logic                    dp_nx;
    logic                    fs_q;
    logic                    slot_tick;
    logic                    last_slot;
    logic                    snap;
    logic                    seen;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_blank;
    logic                    lit;

    assign slot_tick = (presc == PW'(REFRESH_DIV - 1));
    assign last_slot = (idx == IW'(NUM_DIGITS - 1));
    assign snap      = !primed || (slot_tick && last_slot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_tick) begin
            presc <= '0;
            idx   <= last_slot ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blanking is resolved once per frame from the incoming digits so the
    // mask always matches the shadow contents it is loaded alongside.
    always_comb begin
        blank_nx = '0;
        seen     = 1'b0;
        if (BLANK_LEADING) begin
            for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
                if (bus.digits_in[4*(NUM_DIGITS-1-k) +: 4] != 4'd0) seen = 1'b1;
                blank_nx[NUM_DIGITS-1-k] = !seen;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed     <= 1'b0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            blank_mask <= '1;
            fs_q       <= 1'b0;
        end else begin
            fs_q <= snap;
            if (snap) begin
                primed     <= 1'b1;
                sh_digits  <= bus.digits_in;
                sh_dp      <= bus.dp_in;
                sh_en      <= bus.digit_en;
                blank_mask <= blank_nx;
            end
        end
    end

    always_comb begin
        cur_dig   = sh_digits[{idx, 2'b00} +: 4];
        cur_dp    = sh_dp[idx];
        cur_en    = sh_en[idx];
        cur_blank = blank_mask[idx];
        case (cur_dig)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
    end

    // A blanked digit with its decimal point requested stays lit so the dot
    // shows, but with every segment off.
    always_comb begin
        lit    = cur_en && (!cur_blank || cur_dp);
        seg_nx = (cur_en && !cur_blank) ? glyph : 7'h7F;
        dp_nx  = !(lit && cur_dp);
        an_nx  = '1;
        if (lit && (presc >= PW'(GUARD))) an_nx[idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_nx;
            seg_q <= seg_nx;
            dp_q  <= dp_nx;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
endmodule
